// File: rtl/data_sampler_pkg.sv
// data_sampler_pkg: full-buffer policy type and round-robin channel pick shared by the sampler.
package data_sampler_pkg;
  typedef enum logic {DROP_NEW = 1'b0, OVERWRITE_OLDEST = 1'b1} mode_e;
  localparam int MAX_CH = 16;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Scan from farthest to nearest so the first requester after `last` wins.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req, input logic [3:0] last, input int n);
    pick_t p;
    p = '0;
    for (int i = MAX_CH; i >= 1; i--) begin
      logic [3:0] k;
      k = 4'((int'(last) + i) % n);
      if (i <= n && req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/sampler_fifo.sv
// sampler_fifo: one channel's sample buffer; overwrite retires the oldest entry to admit a new one.
module sampler_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              overwrite,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en, rd_en;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_q];
  always_comb begin
    wr_en = push & (~full | pop | overwrite);
    rd_en = pop | overwrite;
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(rd_en);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/multi_ch_data_sampler.sv
// multi_ch_data_sampler: buffers per-channel samples and emits them round-robin, one per sample tick,
// counting samples lost to full buffers.
module multi_ch_data_sampler
  import data_sampler_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       fast_clk,
  input  logic                       rst,
  input  logic                       mode_i,
  input  logic [NUM_CH-1:0]          valid_i,
  input  logic [NUM_CH*DATA_W-1:0]   data_i,
  input  logic                       sample_tick_i,
  input  logic                       clr_cnt_i,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(NUM_CH)-1:0]  ch_o,
  output logic [NUM_CH*CNT_W-1:0]    drop_cnt_o
);
  localparam int CW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] full, empty, req, pop, ovw, drop;
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              valid_q, valid_d, grant, ovw_mode;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     ch_q, ch_d, last_q, last_d, sel;
  pick_t             pick;
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    sampler_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (fast_clk),
      .rst       (rst),
      .push      (valid_i[i]),
      .pop       (pop[i]),
      .overwrite (ovw[i]),
      .din       (data_i[i*DATA_W +: DATA_W]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );
    assign drop_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end
  // Arbitration sees only registered occupancy, so a same-cycle push is never bypassed to the output.
  always_comb begin
    req      = ~empty;
    pick     = rr_pick(MAX_CH'(req), 4'(last_q), NUM_CH);
    sel      = CW'(pick.idx);
    grant    = sample_tick_i & pick.found;
    pop      = grant ? NUM_CH'(1) << sel : '0;
    valid_d  = grant;
    data_d   = grant ? head[sel] : data_q;
    ch_d     = grant ? sel : ch_q;
    last_d   = grant ? sel : last_q;
    ovw_mode = mode_e'(mode_i) == OVERWRITE_OLDEST;
    drop     = valid_i & full & ~pop;
    ovw      = ovw_mode ? drop : '0;
    for (int c = 0; c < NUM_CH; c++)
      cnt_d[c] = clr_cnt_i ? CNT_W'(drop[c]) : cnt_q[c] + CNT_W'(drop[c] && cnt_q[c] != '1);
  end
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= CW'(NUM_CH - 1);
      cnt_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ch_o    = ch_q;
endmodule

// File: tb/tb_multi_ch_data_sampler.sv
// tb_multi_ch_data_sampler: table-driven vectors with an output scoreboard, plus reset corner sequences.
module tb_multi_ch_data_sampler;
  localparam int DW = 64, NC = 4, DP = 4, CW = 2;
  logic              fast_clk = 1'b0, rst = 1'b1, mode_i = 1'b0, sample_tick_i = 1'b0, clr_cnt_i = 1'b0;
  logic [NC-1:0]     valid_i = '0;
  logic [NC*DW-1:0]  data_i = '0;
  logic              valid_o;
  logic [DW-1:0]     data_o;
  logic [1:0]        ch_o;
  logic [NC*CW-1:0]  drop_cnt_o;
  typedef struct {
    logic [3:0] v;
    logic [7:0] val;
    logic       t, m, clr, ev;
    logic [1:0] ech;
    logic [7:0] eval;
    logic [7:0] ecnt;
  } vec_t;
  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;
  vec_t          vecs[$];
  exp_t          sb[$];
  int            errors = 0, checks = 0;
  logic [DW-1:0] hold_data = '0;
  logic [1:0]    hold_ch = '0;

  multi_ch_data_sampler #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .CNT_W(CW)) dut (
    .fast_clk(fast_clk), .rst(rst), .mode_i(mode_i), .valid_i(valid_i), .data_i(data_i),
    .sample_tick_i(sample_tick_i), .clr_cnt_i(clr_cnt_i), .valid_o(valid_o), .data_o(data_o),
    .ch_o(ch_o), .drop_cnt_o(drop_cnt_o));

  always #5 fast_clk = ~fast_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk(input logic [1:0] c, input logic [7:0] v);
    return DW'({c, v});
  endfunction

  task automatic add(input logic [3:0] v, input logic [7:0] val, input logic t, m, clr, ev,
                     input logic [1:0] ech, input logic [7:0] eval, ecnt);
    vec_t r;
    r.v = v; r.val = val; r.t = t; r.m = m; r.clr = clr; r.ev = ev;
    r.ech = ech; r.eval = eval; r.ecnt = ecnt;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    logic want;
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) chk("unexpected valid_o", valid_o, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ch_o", ch_o, e.ch);
        chk("data_o", data_o, e.data);
        hold_ch = e.ch;
        hold_data = e.data;
      end
    end else begin
      want = sb.size() != 0;
      chk("valid_o", valid_o, want);
      if (want) void'(sb.pop_front());
      chk("ch_o hold", ch_o, hold_ch);
      chk("data_o hold", data_o, hold_data);
    end
  endtask

  task automatic run(input vec_t r);
    @(negedge fast_clk);
    valid_i = r.v;
    mode_i = r.m;
    sample_tick_i = r.t;
    clr_cnt_i = r.clr;
    for (int c = 0; c < NC; c++) data_i[c*DW +: DW] = mk(2'(c), r.val);
    if (r.ev) sb.push_back('{r.ech, mk(r.ech, r.eval)});
    @(posedge fast_clk);
    #1;
    check_out();
    chk("drop_cnt_o", drop_cnt_o, r.ecnt);
  endtask

  task automatic run_all();
    foreach (vecs[j]) run(vecs[j]);
    vecs.delete();
  endtask

  initial begin
    repeat (3) add(4'h0, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    // ch0 and ch2 two entries each, alternating grants, fifth tick empty
    add(4'b0101, 8'h07, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'b0101, 8'h08, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h07, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd2, 8'h07, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h08, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd2, 8'h08, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    // ch0 pushes 1,2,3 with a tick every third cycle; then push+tick on empty gives no bypass
    add(4'b0001, 8'h01, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'b0001, 8'h02, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'b0001, 8'h03, 1, 0, 0, 1, 2'd0, 8'h01, 8'h00);
    repeat (2) add(4'h0, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h02, 8'h00);
    repeat (2) add(4'h0, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h03, 8'h00);
    add(4'b0001, 8'h04, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h04, 8'h00);
    // drop-new on ch1, then overwrite-oldest on ch1
    for (int k = 1; k <= 6; k++) add(4'b0010, 8'(k), 0, 0, 0, 0, 2'd0, 8'h00, k == 5 ? 8'h04 : k == 6 ? 8'h08 : 8'h00);
    for (int k = 1; k <= 4; k++) add(4'h0, 8'h00, 1, 0, 0, 1, 2'd1, 8'(k), 8'h08);
    add(4'h0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h08);
    add(4'h0, 8'h00, 0, 0, 1, 0, 2'd0, 8'h00, 8'h00);
    for (int k = 1; k <= 6; k++) add(4'b0010, 8'(k), 0, 1, 0, 0, 2'd0, 8'h00, k == 5 ? 8'h04 : k == 6 ? 8'h08 : 8'h00);
    for (int k = 3; k <= 6; k++) add(4'h0, 8'h00, 1, 1, 0, 1, 2'd1, 8'(k), 8'h08);
    add(4'h0, 8'h00, 0, 0, 1, 0, 2'd0, 8'h00, 8'h00);
    // full ch0 push+pop same cycle, saturation on ch3 with mode toggling, clear coincident with drop
    for (int k = 0; k < 4; k++) add(4'b0001, 8'(8'h11 + k), 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'b0001, 8'h15, 1, 0, 0, 1, 2'd0, 8'h11, 8'h00);
    add(4'b0001, 8'h16, 0, 0, 0, 0, 2'd0, 8'h00, 8'h01);
    for (int k = 1; k <= 4; k++) add(4'b1000, 8'(k), 0, 0, 0, 0, 2'd0, 8'h00, 8'h01);
    add(4'b1000, 8'h05, 0, 0, 0, 0, 2'd0, 8'h00, 8'h41);
    add(4'b1000, 8'h06, 0, 1, 0, 0, 2'd0, 8'h00, 8'h81);
    add(4'b1000, 8'h07, 0, 0, 0, 0, 2'd0, 8'h00, 8'hC1);
    add(4'b1000, 8'h08, 0, 1, 0, 0, 2'd0, 8'h00, 8'hC1);
    add(4'b1000, 8'h09, 0, 0, 0, 0, 2'd0, 8'h00, 8'hC1);
    add(4'b1000, 8'h0A, 0, 0, 1, 0, 2'd0, 8'h00, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd3, 8'h03, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h12, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd3, 8'h04, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h13, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd3, 8'h06, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h14, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd3, 8'h08, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd0, 8'h15, 8'h40);
    add(4'h0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h40);
    add(4'b0100, 8'h21, 0, 0, 0, 0, 2'd0, 8'h00, 8'h40);
    add(4'b0100, 8'h22, 0, 0, 0, 0, 2'd0, 8'h00, 8'h40);

    for (int i = 0; i < 10; i++) begin
      @(negedge fast_clk);
      valid_i = 4'(i);
      sample_tick_i = i[0];
      @(posedge fast_clk);
      #1;
      chk("rst valid_o", valid_o, 0);
      chk("rst drop_cnt_o", drop_cnt_o, 0);
      chk("rst data_o", data_o, 0);
      chk("rst ch_o", ch_o, 0);
    end
    @(negedge fast_clk);
    rst = 1'b0;
    valid_i = '0;
    sample_tick_i = 1'b0;
    run_all();

    // asynchronous reset mid-operation with ch2 holding data
    @(negedge fast_clk);
    valid_i = '0;
    sample_tick_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst valid_o", valid_o, 0);
    chk("async rst drop_cnt_o", drop_cnt_o, 0);
    chk("async rst data_o", data_o, 0);
    chk("async rst ch_o", ch_o, 0);
    hold_data = '0;
    hold_ch = '0;
    @(negedge fast_clk);
    rst = 1'b0;
    add(4'h0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'b0100, 8'h23, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 1, 2'd2, 8'h23, 8'h00);
    add(4'h0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00);
    run_all();

    if (sb.size() != 0) chk("scoreboard leftover", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
